// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_unit_pkg;

    localparam int FETCH_WORD_BYTES = 8;

    typedef struct packed {
        logic [63:0] data;
        logic [30:0] pc;
        logic [1:0]  mask;
    } FetchPacket;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch front-end bus: redirect, line-table lookup, I-cache SRAM and decoder packet port.
interface ifetch_unit_if;
    logic        IN_redirValid;
    logic [30:0] IN_redirPC;
    logic        OUT_lookupValid;
    logic [30:0] OUT_lookupPC;
    logic [27:0] IN_lookupAddress;
    logic        IN_stall;
    logic        OUT_sramRe;
    logic [27:0] OUT_sramAddr;
    logic [63:0] IN_sramData;
    logic        OUT_pktValid;
    logic [63:0] OUT_pktData;
    logic [30:0] OUT_pktPC;
    logic [1:0]  OUT_pktMask;
    logic        IN_pktReady;

    modport master (
        input  IN_redirValid, IN_redirPC, IN_lookupAddress, IN_stall, IN_sramData, IN_pktReady,
        output OUT_lookupValid, OUT_lookupPC, OUT_sramRe, OUT_sramAddr,
               OUT_pktValid, OUT_pktData, OUT_pktPC, OUT_pktMask
    );

    modport slave (
        output IN_redirValid, IN_redirPC, IN_lookupAddress, IN_stall, IN_sramData, IN_pktReady,
        input  OUT_lookupValid, OUT_lookupPC, OUT_sramRe, OUT_sramAddr,
               OUT_pktValid, OUT_pktData, OUT_pktPC, OUT_pktMask
    );
endinterface

// File: rtl/ifetch_unit_fifo.sv
// Circular-buffer packet queue; flush empties it, head reads as zero when empty.
module fetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  FetchPacket       din_i,
    output FetchPacket       head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    FetchPacket       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [CNT_W-1:0] count_q;

    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign head_o  = valid_o ? mem_q[rd_q] : '0;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i && !rst) mem_q[wr_q] <= din_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i && !pop_i) assert (count_q != CNT_W'(DEPTH));
            if (push_i) wr_q <= wr_q + PTR_W'(1);
            if (pop_i)  rd_q <= rd_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// Fetch PC owner: issues line-table lookups, reads the SRAM word, queues packets for decode.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [30:0] RESET_PC    = 31'h0
) (
    input  logic         clk,
    input  logic         rst,
    ifetch_unit_if.master bus
);
    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OFF_W = $clog2(FETCH_WORD_BYTES);

    logic [30:0]      pc_q, pc_d, f1_pc_q, f1_pc_d;
    logic             f1_vld_q, f1_vld_d;
    logic [1:0]       f1_mask_q, f1_mask_d;
    logic [CNT_W-1:0] count, occ;
    logic             credit, issue, push, pop, head_vld;
    FetchPacket       head, din;

    // Credit counts the packet still in F1 so a full queue never sees an unmatched push.
    assign occ    = count + CNT_W'(f1_vld_q);
    assign credit = occ < CNT_W'(QUEUE_DEPTH);
    assign issue  = bus.OUT_lookupValid && !bus.IN_stall;

    assign bus.OUT_lookupValid = !rst && !bus.IN_redirValid && credit;
    assign bus.OUT_lookupPC    = pc_q;
    assign bus.OUT_sramRe      = issue;
    assign bus.OUT_sramAddr    = bus.IN_lookupAddress;

    always_comb begin
        pc_d      = pc_q;
        f1_vld_d  = 1'b0;
        f1_pc_d   = f1_pc_q;
        f1_mask_d = f1_mask_q;
        if (bus.IN_redirValid) begin
            pc_d = bus.IN_redirPC & ~31'h3;
        end else if (issue) begin
            pc_d      = {pc_q[30:OFF_W] + (31-OFF_W)'(1), OFF_W'(0)};
            f1_vld_d  = 1'b1;
            f1_pc_d   = pc_q;
            f1_mask_d = pc_q[2] ? 2'b10 : 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            f1_vld_q  <= 1'b0;
            f1_pc_q   <= '0;
            f1_mask_q <= '0;
        end else begin
            pc_q      <= pc_d;
            f1_vld_q  <= f1_vld_d;
            f1_pc_q   <= f1_pc_d;
            f1_mask_q <= f1_mask_d;
        end
    end

    assign push = f1_vld_q && !bus.IN_redirValid;
    assign pop  = head_vld && bus.IN_pktReady;
    assign din  = '{data: bus.IN_sramData, pc: f1_pc_q, mask: f1_mask_q};

    fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.IN_redirValid),
        .din_i   (din),
        .head_o  (head),
        .valid_o (head_vld),
        .count_o (count)
    );

    assign bus.OUT_pktValid = head_vld;
    assign bus.OUT_pktData  = head.data;
    assign bus.OUT_pktPC    = head.pc;
    assign bus.OUT_pktMask  = head.mask;
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: always-hit table, SRAM word derived from its address.
module tb_ifetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [63:0] sram_q = '0;

    ifetch_unit_if bus();

    ifetch_unit #(.QUEUE_DEPTH(4), .RESET_PC(31'h100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.IN_lookupAddress = bus.OUT_lookupPC[30:3];
    assign bus.IN_sramData      = sram_q;
    always_ff @(posedge clk)
        if (bus.OUT_sramRe) sram_q <= {bus.OUT_sramAddr, 8'hAB, bus.OUT_sramAddr};

    function automatic logic [63:0] exp_data(input logic [30:0] p);
        return {p[30:3], 8'hAB, p[30:3]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus.IN_redirValid = 1'b0;
        bus.IN_redirPC    = '0;
        bus.IN_stall      = 1'b0;
        bus.IN_pktReady   = 1'b0;
        nxt(); nxt(); #1;
        chk("rst_pktValid",    bus.OUT_pktValid, 0);
        chk("rst_lookupValid", bus.OUT_lookupValid, 0);
        chk("rst_sramRe",      bus.OUT_sramRe, 0);
        chk("rst_pktData",     bus.OUT_pktData, 0);
        chk("rst_pktPC",       bus.OUT_pktPC, 0);
        chk("rst_pktMask",     bus.OUT_pktMask, 0);

        // Streaming from RESET_PC.
        nxt(); rst = 1'b0; bus.IN_pktReady = 1'b1; #1;
        chk("s_lookupValid", bus.OUT_lookupValid, 1);
        chk("s_lookupPC",    bus.OUT_lookupPC, 31'h100);
        chk("s_sramRe",      bus.OUT_sramRe, 1);
        nxt(); #1;
        chk("s_noBypass", bus.OUT_pktValid, 0);
        nxt(); #1;
        chk("s_pkt0_valid", bus.OUT_pktValid, 1);
        chk("s_pkt0_pc",    bus.OUT_pktPC, 31'h100);
        chk("s_pkt0_mask",  bus.OUT_pktMask, 2'b11);
        chk("s_pkt0_data",  bus.OUT_pktData, exp_data(31'h100));
        nxt(); #1;
        chk("s_pkt1_pc",    bus.OUT_pktPC, 31'h108);
        nxt(); #1;
        chk("s_pkt2_valid", bus.OUT_pktValid, 1);
        chk("s_pkt2_pc",    bus.OUT_pktPC, 31'h110);
        chk("s_pkt2_data",  bus.OUT_pktData, exp_data(31'h110));

        // Redirect while a push and a pop are both in flight.
        nxt(); bus.IN_redirValid = 1'b1; bus.IN_redirPC = 31'h207; #1;
        chk("r_busyBefore",  bus.OUT_pktValid, 1);
        chk("r_lookupValid", bus.OUT_lookupValid, 0);
        chk("r_sramRe",      bus.OUT_sramRe, 0);
        nxt(); bus.IN_redirValid = 1'b0; #1;
        chk("r_flushed",  bus.OUT_pktValid, 0);
        chk("r_lookupPC", bus.OUT_lookupPC, 31'h204);
        nxt(); #1;
        chk("r_t2_empty", bus.OUT_pktValid, 0);
        nxt(); #1;
        chk("r_t3_valid", bus.OUT_pktValid, 1);
        chk("r_t3_pc",    bus.OUT_pktPC, 31'h204);
        chk("r_t3_mask",  bus.OUT_pktMask, 2'b10);
        nxt(); #1;
        chk("r_t4_pc",    bus.OUT_pktPC, 31'h208);
        chk("r_t4_mask",  bus.OUT_pktMask, 2'b11);

        // Stall held five cycles at 0x40.
        nxt(); bus.IN_redirValid = 1'b1; bus.IN_redirPC = 31'h40;
        for (int i = 0; i < 5; i++) begin
            nxt();
            if (i == 0) begin
                bus.IN_redirValid = 1'b0;
                bus.IN_stall      = 1'b1;
            end
            #1;
            chk("st_lookupPC",    bus.OUT_lookupPC, 31'h40);
            chk("st_lookupValid", bus.OUT_lookupValid, 1);
            chk("st_sramRe",      bus.OUT_sramRe, 0);
        end
        nxt(); bus.IN_stall = 1'b0; #1;
        chk("st_release_re", bus.OUT_sramRe, 1);
        nxt(); #1;
        chk("st_p1_empty", bus.OUT_pktValid, 0);
        nxt(); #1;
        chk("st_p2_valid", bus.OUT_pktValid, 1);
        chk("st_p2_pc",    bus.OUT_pktPC, 31'h40);

        // Decoder stalled: exactly QUEUE_DEPTH packets accepted.
        nxt(); bus.IN_redirValid = 1'b1; bus.IN_redirPC = 31'h300; bus.IN_pktReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            bus.IN_redirValid = 1'b0;
            #1;
            chk("f_issue", bus.OUT_lookupValid, 1);
        end
        for (int i = 0; i < 2; i++) begin
            nxt(); #1;
            chk("f_blocked", bus.OUT_lookupValid, 0);
        end
        nxt(); bus.IN_pktReady = 1'b1; #1;
        chk("f_pulse_blocked", bus.OUT_lookupValid, 0);
        chk("f_head0",         bus.OUT_pktPC, 31'h300);
        nxt(); bus.IN_pktReady = 1'b0; #1;
        chk("f_resume_valid", bus.OUT_lookupValid, 1);
        chk("f_resume_re",    bus.OUT_sramRe, 1);
        chk("f_resume_pc",    bus.OUT_lookupPC, 31'h320);
        chk("f_head1",        bus.OUT_pktPC, 31'h308);
        nxt(); #1;
        chk("f_refull", bus.OUT_lookupValid, 0);
        nxt(); bus.IN_pktReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) nxt();
            #1;
            chk("f_drain_pc",   bus.OUT_pktPC, 31'h308 + 31'(i * 8));
            chk("f_drain_data", bus.OUT_pktData, exp_data(31'h308 + 31'(i * 8)));
        end

        // Reset mid-operation beats a simultaneous redirect.
        nxt(); rst = 1'b1; bus.IN_redirValid = 1'b1; bus.IN_redirPC = 31'h500; #1;
        chk("mr_lookupValid", bus.OUT_lookupValid, 0);
        nxt(); rst = 1'b0; bus.IN_redirValid = 1'b0; #1;
        chk("mr_lookupPC", bus.OUT_lookupPC, 31'h100);
        chk("mr_pktValid", bus.OUT_pktValid, 0);

        // PC wrap at the top of the address space.
        nxt(); bus.IN_redirValid = 1'b1; bus.IN_redirPC = 31'h7FFF_FFF8;
        nxt(); bus.IN_redirValid = 1'b0; #1;
        chk("w_lookupPC", bus.OUT_lookupPC, 31'h7FFF_FFF8);
        chk("w_sramRe",   bus.OUT_sramRe, 1);
        nxt(); #1;
        chk("w_wrapPC", bus.OUT_lookupPC, 31'h0);
        nxt(); #1;
        chk("w_pkt_valid", bus.OUT_pktValid, 1);
        chk("w_pkt_pc",    bus.OUT_pktPC, 31'h7FFF_FFF8);
        nxt(); #1;
        chk("w_pkt_next",  bus.OUT_pktPC, 31'h0);
        chk("w_pkt_mask",  bus.OUT_pktMask, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
